// File: rtl/load_store_unit_pkg.sv
// Shared types and funct3 decode helpers for the load/store unit.
// Used by load_store_unit and lsu_load_align.
package pkg_lsu;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return f3 inside {F3_SB, F3_SH, F3_SW};
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  // funct3[1:0] encodes the access size for every legal load/store code.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request, response and memory-bus signals of the load/store unit.
// slave = the LSU itself; master = the core plus memory around it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        rsp_misaligned;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_misaligned,
           mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_misaligned,
           mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Load lane select and sign/zero extension of a memory word (combinational).
module lsu_load_align
  import pkg_lsu::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    byte_sel = word[8*addr +: 8];
    half_sel = word[16*addr[1] +: 16];
    result   = word;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sub-word load/store engine: one request -> one word-aligned memory access -> one response.
// Optional LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses respond with rsp_misaligned.
module load_store_unit
  import pkg_lsu::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t  state, state_nxt;
  logic          write_q, fault_q, misal_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q, wdata_q, rdata_q, load_data;
  logic [3:0]    wstrb_q;
  logic [CW-1:0] wait_cnt;
  logic          req_legal, req_misal, req_ok, timed_out;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;

  always_comb begin
    req_misal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    req_misal = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`endif
    req_legal = f3_legal(bus.req_write, bus.req_funct3);
    req_ok    = req_legal && !req_misal;
    timed_out = (TIMEOUT > 0) && (wait_cnt == CW'(TIMEOUT - 1));
  end

  // Store lane steering; the strobe shift ignores the sub-size address bits.
  always_comb begin
    st_wdata = bus.req_wdata;
    st_wstrb = 4'b1111;
    case (bus.req_funct3)
      F3_SB: begin
        st_wdata = {4{bus.req_wdata[7:0]}};
        st_wstrb = 4'b0001 << bus.req_addr[1:0];
      end
      F3_SH: begin
        st_wdata = {2{bus.req_wdata[15:0]}};
        st_wstrb = 4'b0011 << {bus.req_addr[1], 1'b0};
      end
      default: ;
    endcase
    if (!bus.req_write) st_wstrb = 4'b0000;
  end

  lsu_load_align u_align (
    .funct3 (f3_q),
    .addr   (addr_q[1:0]),
    .word   (bus.mem_rdata),
    .result (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = req_ok ? ACCESS : RESP;
      ACCESS:  if (bus.mem_ready || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    bus.req_ready      = (state == IDLE);
    bus.mem_valid      = (state == ACCESS);
    bus.mem_write      = (state == ACCESS) && write_q;
    bus.mem_addr       = {addr_q[31:2], 2'b00};
    bus.mem_wdata      = wdata_q;
    bus.mem_wstrb      = wstrb_q;
    bus.rsp_valid      = (state == RESP);
    bus.rsp_rdata      = rdata_q;
    bus.rsp_fault      = (state == RESP) && fault_q;
    bus.rsp_misaligned = (state == RESP) && misal_q;
  end

  // NOTE: datapath registers are reset too, because the memory-side outputs have defined reset values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q  <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'b0000;
      wait_cnt <= '0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
      misal_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          write_q  <= bus.req_write;
          f3_q     <= bus.req_funct3;
          addr_q   <= bus.req_addr;
          wdata_q  <= st_wdata;
          wstrb_q  <= st_wstrb;
          wait_cnt <= '0;
          rdata_q  <= 32'h0;
          fault_q  <= !req_legal;
          misal_q  <= req_legal && req_misal;
        end
        ACCESS: begin
          if (bus.mem_ready)  rdata_q  <= write_q ? 32'h0 : load_data;
          else if (timed_out) fault_q  <= 1'b1;
          else                wait_cnt <= wait_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors, random traffic against a
// size/lane arithmetic reference model, timeout, illegal funct3 and reset during an access.
module tb_load_store_unit;
  import pkg_lsu::*;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic        fault;
    logic        misal;
    logic        access;
    int          cycles;
  } exp_t;

  // Reference: size = funct3 % 4 bytes-log2, lane = addr % 4, data moved with shifts and masks.
  function automatic exp_t model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] word, input int delay);
    exp_t e;
    int lane, size, nbytes, off;
    logic legal;
    logic [31:0] v;
    lane   = int'(a % 4);
    size   = int'(f3 % 4);
    nbytes = 1 << size;
    legal  = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    e.misal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    e.misal = legal && (lane % nbytes != 0);
`endif
    e.fault  = !legal;
    e.access = legal && !e.misal;
    e.cycles = !e.access ? 0 : (delay >= TIMEOUT ? TIMEOUT : delay + 1);
    if (e.access && delay >= TIMEOUT) e.fault = 1'b1;
    off     = (lane / nbytes) * nbytes;
    e.addr  = a - 32'(lane);
    e.wstrb = wr ? 4'(((1 << nbytes) - 1) << off) : 4'b0000;
    case (size)
      0:       e.wdata = (wd & 32'hff) * 32'h01010101;
      1:       e.wdata = (wd & 32'hffff) * 32'h00010001;
      default: e.wdata = wd;
    endcase
    e.rdata = 32'h0;
    if (e.access && !e.fault && !wr) begin
      if (nbytes == 4) v = word;
      else begin
        v = (word >> (8 * off)) & ((32'd1 << (8 * nbytes)) - 32'd1);
        if (f3 < 3'd4 && v >= (32'd1 << (8 * nbytes - 1))) v = v - (32'd1 << (8 * nbytes));
      end
      e.rdata = v;
    end
    return e;
  endfunction

  // Presents one request at the current negedge and plays memory with `delay` wait cycles.
  task automatic run_access(input string name, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] word, input int delay);
    exp_t e;
    int acc, n;
    e = model(wr, f3, a, wd, word, delay);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s accept req_ready: got %b want 1", name, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_write = 1'($urandom);
    acc = 0; n = 0;
    while (!bus.rsp_valid && n < 40) begin
      n_cmp++;
      if (bus.req_ready !== 1'b0) begin
        n_err++; $display("FAIL %s busy req_ready: got %b want 0", name, bus.req_ready);
      end
      if (bus.mem_valid === 1'b1) begin
        n_cmp++;
        if (bus.mem_addr !== e.addr || bus.mem_wstrb !== e.wstrb || bus.mem_write !== wr ||
            (wr && bus.mem_wdata !== e.wdata)) begin
          n_err++;
          $display("FAIL %s mem bus: got addr=%h strb=%b wr=%b wdata=%h want addr=%h strb=%b wr=%b wdata=%h",
                   name, bus.mem_addr, bus.mem_wstrb, bus.mem_write, bus.mem_wdata,
                   e.addr, e.wstrb, wr, e.wdata);
        end
        if (acc == delay) begin bus.mem_ready = 1'b1; bus.mem_rdata = word; end
        else begin bus.mem_ready = 1'b0; bus.mem_rdata = $urandom; end
        acc++;
      end
      @(negedge clk);
      n++;
    end
    bus.mem_ready = 1'b0;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL %s response timeout: got no rsp_valid want rsp_valid", name);
    end
    n_cmp++;
    if (acc != e.cycles || n != e.cycles) begin
      n_err++; $display("FAIL %s access cycles: got %0d (latency %0d) want %0d", name, acc, n, e.cycles);
    end
    n_cmp++;
    if (bus.rsp_rdata !== e.rdata || bus.rsp_fault !== e.fault || bus.rsp_misaligned !== e.misal) begin
      n_err++;
      $display("FAIL %s response: got rdata=%h fault=%b mis=%b want rdata=%h fault=%b mis=%b",
               name, bus.rsp_rdata, bus.rsp_fault, bus.rsp_misaligned, e.rdata, e.fault, e.misal);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s after resp: got rsp_valid=%b req_ready=%b want 0/1",
                        name, bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_fault !== 1'b0 ||
        bus.rsp_misaligned !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.mem_valid !== 1'b0 ||
        bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 ||
        bus.mem_wstrb !== 4'b0000) begin
      n_err++;
      $display("FAIL reset values: got rdy=%b rv=%b f=%b m=%b rd=%h mv=%b mw=%b a=%h wd=%h s=%b want 1,0,0,0,0,0,0,0,0,0",
               bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.rsp_misaligned, bus.rsp_rdata,
               bus.mem_valid, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_access("lw_a8",  1'b0, F3_LW,  32'ha8, 32'h0,    32'hdeadbeef, 0);
    run_access("lb_ab",  1'b0, F3_LB,  32'hab, 32'h0,    32'hdeadbeef, 0);
    run_access("lbu_ab", 1'b0, F3_LBU, 32'hab, 32'h0,    32'hdeadbeef, 1);
    run_access("lh_aa",  1'b0, F3_LH,  32'haa, 32'h0,    32'hdeadbeef, 0);
    run_access("lhu_a8", 1'b0, F3_LHU, 32'ha8, 32'h0,    32'hdeadbeef, 2);
    run_access("sb_a9",  1'b1, F3_SB,  32'ha9, 32'h12,   32'h55aa55aa, 0);
    run_access("sh_ae",  1'b1, F3_SH,  32'hae, 32'hcafe, 32'h0,        0);
    run_access("sw_b0",  1'b1, F3_SW,  32'hb0, 32'h89abcdef, 32'h0,    1);
    run_access("lw_a6",  1'b0, F3_LW,  32'ha6, 32'h0,    32'h01234567, 0);
    run_access("lh_odd", 1'b0, F3_LH,  32'ha1, 32'h0,    32'h8001ff7f, 0);
  endtask

  task automatic test_wait_states();
    run_access("lw_wait3",  1'b0, F3_LW, 32'h40, 32'h0,  32'h13579bdf, 3);
    run_access("sb_wait2",  1'b1, F3_SB, 32'h43, 32'h9c, 32'h0,        2);
  endtask

  task automatic test_timeout_illegal();
    run_access("lw_timeout", 1'b0, F3_LW, 32'h80, 32'h0, 32'hffffffff, 99);
    run_access("sh_timeout", 1'b1, F3_SH, 32'h82, 32'h1234, 32'h0,     99);
    run_access("ld_f3_011",  1'b0, 3'b011, 32'h84, 32'h0, 32'h0,       0);
    run_access("st_f3_100",  1'b1, 3'b100, 32'h88, 32'h7, 32'h0,       0);
    run_access("ld_f3_111",  1'b0, 3'b111, 32'h8c, 32'h0, 32'h0,       0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_access("b2b", 1'($urandom), 3'($urandom_range(0, 5)), $urandom, $urandom, $urandom, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_access("rand", 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 5)));
  endtask

  task automatic test_reset_mid_access();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = F3_LW; bus.req_addr = 32'h100;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_reset pre mem_valid: got %b want 1", bus.mem_valid);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset async: got mem_valid=%b req_ready=%b want 0/1",
                        bus.mem_valid, bus.req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin
        n_err++; $display("FAIL mid_reset quiet: got rsp_valid=%b mem_valid=%b want 0/0",
                          bus.rsp_valid, bus.mem_valid);
      end
    end
    run_access("post_reset", 1'b0, F3_LHU, 32'h102, 32'h0, 32'hfedc0000, 1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wait_states();
    test_timeout_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
